// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Barrel-shifter operand sequencer. Classifies the accepted
//               instruction word, drives the shift-amount-maker code and
//               inserts an Rs register-file read for register-specified
//               shifts. Define SHIFT_SEQ_PERF_EN to add the stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ir_valid,
    input  logic [31:0] ir_in,
    output logic        ir_ready,
    input  logic        flush,
    output logic        rf_rd_en,
    output logic [3:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ir2,
    output logic [31:0] reg_value,
    output logic [1:0]  sam_ctrl,
    output logic        shift_bypass
`ifdef SHIFT_SEQ_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RS_REQ = 2'd1;
    localparam logic [1:0] c_RS_CAP = 2'd2;
    localparam logic [1:0] c_VALID  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_ir2;
    logic [31:0] r_reg_value;
    logic [1:0]  r_sam_ctrl;
    logic        r_shift_bypass;

    logic [1:0]  w_sam;
    logic        w_bypass;
    logic        w_reg_shift;
    logic        w_accept;

    // Operand classification of the incoming word, registered on accept.
    always_comb begin
        w_sam       = 2'b00;
        w_bypass    = 1'b1;
        w_reg_shift = 1'b0;
        case (ir_in[27:25])
            3'b001: begin
                w_sam    = 2'b11;
                w_bypass = 1'b0;
            end
            3'b000: begin
                if (!ir_in[4]) begin
                    w_bypass = 1'b0;
                end else if (!ir_in[7]) begin
                    w_sam       = 2'b01;
                    w_bypass    = 1'b0;
                    w_reg_shift = 1'b1;
                end
            end
            3'b011: w_bypass = 1'b0;
            3'b101: begin
                w_sam    = 2'b10;
                w_bypass = 1'b0;
            end
            default: ;
        endcase
    end

    assign ir_ready = !flush && ((r_state == c_IDLE) ||
                                 ((r_state == c_VALID) && ex_ready));
    assign w_accept = ir_valid && ir_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state        <= c_IDLE;
            r_ir2          <= 32'd0;
            r_reg_value    <= 32'd0;
            r_sam_ctrl     <= 2'b00;
            r_shift_bypass <= 1'b0;
        end else if (flush) begin
            // Only the sequencing state is discarded; held fields stay.
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_RS_REQ: r_state <= c_RS_CAP;
                c_RS_CAP: begin
                    r_reg_value <= rf_rd_data;
                    r_state     <= c_VALID;
                end
                c_VALID: begin
                    if (ex_ready && !ir_valid) begin
                        r_state <= c_IDLE;
                    end
                end
                default: ;
            endcase
            if (w_accept) begin
                r_ir2          <= ir_in;
                r_sam_ctrl     <= w_sam;
                r_shift_bypass <= w_bypass;
                if (w_reg_shift) begin
                    r_state <= c_RS_REQ;
                end else begin
                    r_state     <= c_VALID;
                    r_reg_value <= 32'd0;
                end
            end
        end
    end

    assign rf_rd_en     = (r_state == c_RS_REQ);
    assign rf_rd_addr   = r_ir2[11:8];
    assign ex_valid     = (r_state == c_VALID);
    assign ir2          = r_ir2;
    assign reg_value    = r_reg_value;
    assign sam_ctrl     = r_sam_ctrl;
    assign shift_bypass = r_shift_bypass;

`ifdef SHIFT_SEQ_PERF_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state == c_RS_REQ) || (r_state == c_RS_CAP) ||
                     ((r_state == c_VALID) && !ex_ready);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the barrel-shifter operand path in the execute stage. Accepts one decoded instruction word at a time, classifies its shifter operand, and drives the 2-bit shift-amount-maker control code. For register-specified shifts, it inserts a register-file read cycle to fetch Rs before presenting the operand bundle to execute over a valid/ready handshake.

## Interface
- No parameters.
- `clk` in 1: clock, all state updates on rising edge.
- `nreset` in 1: asynchronous active-low reset.
- `ir_valid` in 1: upstream instruction word valid.
- `ir_in` in 32: upstream instruction word.
- `ir_ready` out 1: controller accepts `ir_in` this cycle.
- `flush` in 1: synchronous pipeline flush; discards held instruction.
- `rf_rd_en` out 1: Rs read request to register-file shift port.
- `rf_rd_addr` out 4: Rs index (`ir[11:8]` of held word).
- `rf_rd_data` in 32: Rs value, valid the cycle after `rf_rd_en`.
- `ex_valid` out 1: operand bundle valid to execute.
- `ex_ready` in 1: execute consumes bundle.
- `ir2` out 32: held instruction word.
- `reg_value` out 32: latched Rs value (0 unless register shift).
- `sam_ctrl` out 2: 00 imm shift, 01 register shift, 10 LSL #2, 11 rotated immediate.
- `shift_bypass` out 1: operand needs no shift; execute passes operand unshifted.
- `stall_cnt` out 16: present only with `SHIFT_SEQ_PERF_EN`.

## Operation
- Classification of accepted word `w` (registered at acceptance):
  - `w[27:25]=001`: `sam_ctrl=11`, bypass 0.
  - `w[27:25]=000`, `w[4]=0`: `sam_ctrl=00`, bypass 0.
  - `w[27:25]=000`, `w[4]=1`, `w[7]=0`: `sam_ctrl=01`, bypass 0, register shift.
  - `w[27:25]=000`, `w[7]=1`, `w[4]=1` (multiply/extra load-store): `sam_ctrl=00`, bypass 1.
  - `w[27:25]=011`: `sam_ctrl=00`, bypass 0.
  - `w[27:25]=101`: `sam_ctrl=10`, bypass 0.
  - All others: `sam_ctrl=00`, bypass 1.
- FSM states:
  - IDLE: empty, `ir_ready=1`.
  - RS_REQ: `rf_rd_en=1`, `rf_rd_addr=ir2[11:8]`.
  - RS_CAP: captures `rf_rd_data` into `reg_value` at the cycle end.
  - VALID: `ex_valid=1`, outputs held stable until `ex_ready`.
- Transitions:
  - On accept, go to RS_REQ for a register shift, otherwise to VALID. `reg_value` is cleared to 0 on a non-register-shift accept.
  - RS_REQ always goes to RS_CAP.
  - RS_CAP always goes to VALID.
  - VALID with `ex_ready`: if `ir_valid`, accept the next word and go to its first state; otherwise go to IDLE.
- `ir_ready = !flush && (IDLE || (VALID && ex_ready))`.
- `flush` has the highest priority. Next state is IDLE, `ex_valid` drops the next cycle, and no word is accepted in the flush cycle. A read in flight in RS_REQ/RS_CAP is abandoned and `rf_rd_data` is ignored. `ir2`, `reg_value` and `sam_ctrl` keep their values; only the state clears.
- While `ex_valid` is high and `ex_ready` is low, `ir2`, `reg_value`, `sam_ctrl` and `shift_bypass` must not change.

## Timing
- Reset values: IDLE, `ir_ready=1`, `ex_valid=0`, `rf_rd_en=0`, `rf_rd_addr=0`, `ir2=0`, `reg_value=0`, `sam_ctrl=00`, `shift_bypass=0`, `stall_cnt=0`.
- Non-register-shift latency: accept at edge T, `ex_valid` high in cycle T+1.
- Register-shift latency: accept at T; `rf_rd_en` in T+1; data sampled at end of T+2; `ex_valid` in T+3.
- Throughput: one non-register-shift word per cycle with `ex_ready` held high. A register shift costs 2 bubble cycles.
- `nreset` asserted mid-operation returns to IDLE immediately and asynchronously; the held word is lost.

## Configuration
- `SHIFT_SEQ_PERF_EN` defined:
  - `stall_cnt` port exists.
  - Increments once per cycle in RS_REQ or RS_CAP, plus once per cycle in VALID with `ex_ready=0`.
  - Saturates at 16'hFFFF. Cleared only by reset.
- `SHIFT_SEQ_PERF_EN` undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset then `ir_in=32'hE2811003` (ADD imm) with `ex_ready=1` -> `ex_valid` next cycle, `sam_ctrl=11`, `shift_bypass=0`, `reg_value=0`.
- `ir_in=32'hE0810312` (ADD r0,r1,r2,LSL r3), `rf_rd_data=32'h00000105` -> `rf_rd_en` at T+1 with `rf_rd_addr=3`; at T+3 `ex_valid=1`, `sam_ctrl=01`, `reg_value=32'h105`; with perf enabled, `stall_cnt=2`.
- Back-to-back `32'hEA000010` (B) then `32'hE7910102` (LDR reg) with `ex_ready=1` -> consecutive cycles: `sam_ctrl=10` then `00`, `ir_ready` high throughout.
- `ex_ready=0` for 3 cycles while VALID holding `32'hE0000090` (MUL) -> `sam_ctrl=00` and `shift_bypass=1` held stable, `ir_ready=0`, `ex_valid=1` throughout; perf `stall_cnt=3`.
- `flush` asserted in RS_CAP of a register-shift word -> next cycle IDLE, `ex_valid=0`, `rf_rd_data` ignored, next word accepted the cycle after.
- `nreset` low during RS_REQ -> all outputs at reset values immediately, without waiting for a clock edge.
